// File: rtl/cp0_timer.sv
// ---------------------------------------------------------------------------
// cp0_timer : MIPS-style coprocessor 0 with an optional Count/Compare timer.
//
// Holds SR, Cause, EPC, BadVAddr, PRId, Count and Compare. Decides in the
// same cycle whether to take an exception or interrupt (Req) and supplies
// the EPC value that the next-PC logic should use.
//
// Ports
//   clk, reset     : clock, synchronous active-high reset
//   A1 / DOut      : mfc0 read register number / read data (no side effects)
//   A2, Din, WE    : mtc0 write register number, data, enable
//   PC             : PC of the faulting or interrupted instruction
//   isInDelaySlot  : that instruction sits in a branch delay slot
//   ExcCodeIn      : exception code, 0 = none
//   BadAddrIn      : faulting address for ExcCode 4/5
//   HWInt          : external interrupt levels
//   EXLClr         : eret, clears SR.EXL
//   Req            : take exception/interrupt this cycle
//   EPCOut         : EPC to next-PC logic (target value while Req=1)
//   TimerInt       : timer pending bit, Cause[7]
// ---------------------------------------------------------------------------
module cp0_timer #(
  parameter int          NUM_HWINT = 6,
  parameter logic [31:0] PRID_VAL  = 32'h2002_0907,
  parameter bit          TIMER_EN  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           A1,
  input  logic [4:0]           A2,
  input  logic [31:0]          Din,
  input  logic                 WE,
  input  logic [31:0]          PC,
  input  logic                 isInDelaySlot,
  input  logic [4:0]           ExcCodeIn,
  input  logic [31:0]          BadAddrIn,
  input  logic [NUM_HWINT-1:0] HWInt,
  input  logic                 EXLClr,
  output logic                 Req,
  output logic [31:0]          EPCOut,
  output logic [31:0]          DOut,
  output logic                 TimerInt
);

  // SR fields
  logic                 r_ie;
  logic                 r_exl;
  logic                 r_im_t;
  logic [NUM_HWINT-1:0] r_im;
  // Cause fields
  logic [4:0]           r_exccode;
  logic                 r_ip_t;
  logic [NUM_HWINT-1:0] r_ip;
  logic                 r_bd;
  // Full-width registers
  logic [31:0]          r_epc;
  logic [31:0]          r_badvaddr;
  logic [31:0]          r_count;
  logic [31:0]          r_compare;

  logic                 w_int_pending;
  logic                 w_exc_pending;
  logic                 w_req;
  logic [31:0]          w_epc_target;
  logic                 w_wr;
  logic                 w_wr_sr;
  logic                 w_wr_epc;
  logic                 w_wr_count;
  logic                 w_wr_compare;
  logic                 w_bad_addr_exc;
  logic [31:0]          w_sr;
  logic [31:0]          w_cause;

  // Interrupt sources: timer pending bit on top of the external lines,
  // each gated by its mask bit, all gated by the global enable.
  assign w_int_pending = r_ie && (|({r_ip_t, HWInt} & {r_im_t, r_im}));
  assign w_exc_pending = (ExcCodeIn != 5'd0);
  assign w_req         = !r_exl && (w_exc_pending || w_int_pending);
  assign w_epc_target  = isInDelaySlot ? (PC - 32'd4) : PC;

  // mtc0 writes are dropped in a cycle that takes an exception/interrupt
  assign w_wr         = WE && !w_req;
  assign w_wr_sr      = w_wr && (A2 == 5'd12);
  assign w_wr_epc     = w_wr && (A2 == 5'd14);
  assign w_wr_count   = w_wr && (A2 == 5'd9);
  assign w_wr_compare = w_wr && (A2 == 5'd11);

  // BadVAddr captures only for a genuine address exception; an interrupt
  // taken in the same cycle takes priority and leaves it alone.
  assign w_bad_addr_exc = !w_int_pending &&
                          ((ExcCodeIn == 5'd4) || (ExcCodeIn == 5'd5));

  assign Req      = w_req;
  assign EPCOut   = w_req ? w_epc_target : r_epc;
  assign TimerInt = r_ip_t;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ie       <= 1'b0;
      r_exl      <= 1'b0;
      r_im_t     <= 1'b0;
      r_im       <= '0;
      r_exccode  <= 5'd0;
      r_ip       <= '0;
      r_bd       <= 1'b0;
      r_epc      <= 32'd0;
      r_badvaddr <= 32'd0;
    end else begin
      r_ip <= HWInt;
      if (w_req) begin
        r_exl     <= 1'b1;
        r_bd      <= isInDelaySlot;
        r_epc     <= w_epc_target;
        r_exccode <= w_int_pending ? 5'd0 : ExcCodeIn;
        if (w_bad_addr_exc) begin
          r_badvaddr <= BadAddrIn;
        end
      end else begin
        if (w_wr_sr) begin
          r_ie   <= Din[0];
          r_exl  <= Din[1];
          r_im_t <= Din[7];
          r_im   <= Din[10 +: NUM_HWINT];
        end
        // eret overrides an SR write's EXL bit
        if (EXLClr) begin
          r_exl <= 1'b0;
        end
        if (w_wr_epc) begin
          r_epc <= Din;
        end
      end
    end
  end

  generate
    if (TIMER_EN) begin : g_timer
      always_ff @(posedge clk) begin
        if (reset) begin
          r_count   <= 32'd0;
          r_compare <= 32'd0;
          r_ip_t    <= 1'b0;
        end else begin
          r_count <= w_wr_count ? Din : (r_count + 32'd1);
          if (w_wr_compare) begin
            r_compare <= Din;
          end
          // A Compare write acknowledges the timer and beats a same-cycle match
          if (w_wr_compare) begin
            r_ip_t <= 1'b0;
          end else if (r_count == r_compare) begin
            r_ip_t <= 1'b1;
          end
        end
      end
    end else begin : g_no_timer
      assign r_count   = 32'd0;
      assign r_compare = 32'd0;
      assign r_ip_t    = 1'b0;
    end
  endgenerate

  always_comb begin
    w_sr                    = 32'd0;
    w_sr[0]                 = r_ie;
    w_sr[1]                 = r_exl;
    w_sr[7]                 = r_im_t;
    w_sr[10 +: NUM_HWINT]   = r_im;
    w_cause                 = 32'd0;
    w_cause[6:2]            = r_exccode;
    w_cause[7]              = r_ip_t;
    w_cause[10 +: NUM_HWINT] = r_ip;
    w_cause[31]             = r_bd;
  end

  always_comb begin
    case (A1)
      5'd8:    DOut = r_badvaddr;
      5'd9:    DOut = r_count;
      5'd11:   DOut = r_compare;
      5'd12:   DOut = w_sr;
      5'd13:   DOut = w_cause;
      5'd14:   DOut = r_epc;
      5'd15:   DOut = PRID_VAL;
      default: DOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_timer.sv
// ---------------------------------------------------------------------------
// tb_cp0_timer : directed stimulus with hand-computed expectations pushed to
// a scoreboard queue; a negedge monitor pops and compares the entries that
// belong to the current cycle.
// ---------------------------------------------------------------------------
module tb_cp0_timer;

  localparam logic [31:0] PRID = 32'h2002_0907;
  localparam int S_REQ  = 0;
  localparam int S_EPC  = 1;
  localparam int S_DOUT = 2;
  localparam int S_TINT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2, ExcCodeIn;
  logic [31:0] Din, PC, BadAddrIn;
  logic        WE, isInDelaySlot, EXLClr;
  logic [5:0]  HWInt;
  logic        Req, TimerInt;
  logic [31:0] EPCOut, DOut;

  cp0_timer dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .Din(Din), .WE(WE),
    .PC(PC), .isInDelaySlot(isInDelaySlot), .ExcCodeIn(ExcCodeIn),
    .BadAddrIn(BadAddrIn), .HWInt(HWInt), .EXLClr(EXLClr),
    .Req(Req), .EPCOut(EPCOut), .DOut(DOut), .TimerInt(TimerInt)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
    int          cyc;
  } chk_t;

  chk_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Monitor: compare every scoreboard entry issued for this cycle
  initial begin
    chk_t        c;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        c = sb.pop_front();
        case (c.sel)
          S_REQ:   act = {31'd0, Req};
          S_EPC:   act = EPCOut;
          S_DOUT:  act = DOut;
          default: act = {31'd0, TimerInt};
        endcase
        n_checks = n_checks + 1;
        if (act === c.exp && c.cyc == cyc) begin
          n_pass = n_pass + 1;
          $display("ok   cyc=%0d %s = %h", cyc, c.name, act);
        end else begin
          $display("FAIL cyc=%0d %s actual=%h required=%h", cyc, c.name, act, c.exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: stimulus did not complete, pending=%0d", sb.size());
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int sel, input logic [31:0] v);
    chk_t c;
    c.name = nm;
    c.sel  = sel;
    c.exp  = v;
    c.cyc  = cyc;
    sb.push_back(c);
  endtask

  task automatic rd(input logic [4:0] a, input string nm, input logic [31:0] v);
    A1 = a;
    chk(nm, S_DOUT, v);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    WE  = 1'b1;
    A2  = a;
    Din = d;
  endtask

  task automatic idle();
    WE = 1'b0; A2 = 5'd0; Din = 32'd0; EXLClr = 1'b0; ExcCodeIn = 5'd0;
    HWInt = 6'd0; PC = 32'd0; isInDelaySlot = 1'b0; BadAddrIn = 32'd0;
  endtask

  initial begin
    reset = 1'b1;
    A1    = 5'd0;
    idle();
    step();
    step();
    // Reset held: registers read zero, PRId reads its constant
    rd(5'd15, "rst_prid", PRID); chk("rst_req", S_REQ, 32'd0); step();
    rd(5'd12, "rst_sr", 32'd0); chk("rst_tint", S_TINT, 32'd0); step();
    rd(5'd9, "rst_count", 32'd0); step();
    reset = 1'b0;
    rd(5'd13, "rst_cause", 32'd0); step();
    // Count==Compare==0 right after reset sets the timer bit one cycle later
    rd(5'd9, "count_inc", 32'd1); chk("tint_post_rst", S_TINT, 32'd1);
    wr(5'd11, 32'h1000_0000); step(); idle();
    rd(5'd11, "compare_rd", 32'h1000_0000); chk("tint_cleared", S_TINT, 32'd0);
    wr(5'd12, 32'h0000_0401); step(); idle();
    // Interrupt and exception together: interrupt wins
    rd(5'd12, "sr_rd", 32'h0000_0401);
    HWInt = 6'd1; ExcCodeIn = 5'd10; PC = 32'h0000_1234;
    chk("irq_req", S_REQ, 32'd1); chk("irq_epcout", S_EPC, 32'h0000_1234); step(); idle();
    rd(5'd13, "irq_cause", 32'h0000_0400); chk("exl_blocks_req", S_REQ, 32'd0); step();
    rd(5'd14, "irq_epc", 32'h0000_1234); chk("epcout_reg", S_EPC, 32'h0000_1234); step();
    // EXL=1 masks a pending exception; then eret + SR write together
    rd(5'd12, "sr_exl_set", 32'h0000_0403); ExcCodeIn = 5'd4;
    chk("exl_masks_exc", S_REQ, 32'd0); step();
    ExcCodeIn = 5'd4; EXLClr = 1'b1; wr(5'd12, 32'h0000_0001);
    chk("exl_masks_exc2", S_REQ, 32'd0); step(); idle();
    rd(5'd12, "sr_after_eret", 32'h0000_0001); chk("idle_req", S_REQ, 32'd0); step();
    // Address exception from a delay slot
    ExcCodeIn = 5'd4; PC = 32'h0000_3010; isInDelaySlot = 1'b1; BadAddrIn = 32'h0000_1003;
    rd(5'd8, "badv_before", 32'd0);
    chk("ds_req", S_REQ, 32'd1); chk("ds_epcout", S_EPC, 32'h0000_300C); step(); idle();
    rd(5'd13, "ds_cause", 32'h8000_0010); step();
    rd(5'd8, "ds_badvaddr", 32'h0000_1003); step();
    rd(5'd14, "ds_epc", 32'h0000_300C); step();
    EXLClr = 1'b1; step(); idle();
    // mtc0 EPC suppressed while Req=1
    ExcCodeIn = 5'd8; PC = 32'h0000_0400; wr(5'd14, 32'h0000_DEAD);
    chk("sys_req", S_REQ, 32'd1); step(); idle();
    rd(5'd14, "epc_not_dead", 32'h0000_0400); step();
    rd(5'd8, "badv_kept", 32'h0000_1003); step();
    // Timer wrap and match
    EXLClr = 1'b1; wr(5'd9, 32'hFFFF_FFFE); step(); idle();
    wr(5'd11, 32'h0000_0001); step(); idle();
    rd(5'd9, "count_ffff", 32'hFFFF_FFFF); wr(5'd12, 32'h0000_0081); step(); idle();
    rd(5'd9, "count_wrap0", 32'd0); chk("tint_w0", S_TINT, 32'd0); chk("req_w0", S_REQ, 32'd0); step();
    rd(5'd9, "count_1", 32'd1); chk("tint_w1", S_TINT, 32'd0); chk("req_w1", S_REQ, 32'd0); step();
    PC = 32'h0000_0500;
    rd(5'd13, "timer_cause", 32'h0000_00A0); chk("tint_set", S_TINT, 32'd1);
    chk("timer_req", S_REQ, 32'd1); chk("timer_epcout", S_EPC, 32'h0000_0500); step(); idle();
    rd(5'd13, "timer_cause2", 32'h0000_0080); chk("tint_sticky", S_TINT, 32'd1);
    chk("timer_exl", S_REQ, 32'd0); wr(5'd11, 32'h1000_0000); step(); idle();
    rd(5'd14, "timer_epc", 32'h0000_0500); chk("tint_ack", S_TINT, 32'd0); step();
    rd(5'd10, "unmapped_rd", 32'd0); wr(5'd9, 32'h0000_0055); step(); idle();
    // Reset mid-operation
    rd(5'd9, "count_55", 32'h0000_0055); reset = 1'b1; step();
    rd(5'd9, "rst2_count", 32'd0); chk("rst2_tint", S_TINT, 32'd0); step();
    rd(5'd12, "rst2_sr", 32'd0); chk("rst2_req", S_REQ, 32'd0); step();
    rd(5'd13, "rst2_cause", 32'd0); step();
    rd(5'd14, "rst2_epc", 32'd0); step();
    rd(5'd8, "rst2_badv", 32'd0); step();
    rd(5'd11, "rst2_compare", 32'd0); step();
    rd(5'd15, "rst2_prid", PRID); step();
    reset = 1'b0;
    step();
    n_checks = n_checks + 1;
    if (sb.size() == 0) n_pass = n_pass + 1;
    else $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
